// File: rtl/game_round_ctrl.sv
// Round controller for the memory-sequence game: generate -> playback -> input -> check -> result.
// Latency: outputs are registered from next_state, so they are valid in the first cycle of each new state.
// Backpressure: none; waits on seq_ready / play_done / input_done / time_up handshakes from the peripherals.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   restart           synchronous pulse, aborts the game back to IDLE with counters re-initialised
//   seq_ready         generator has a valid answer_seq
//   answer_seq        expected sequence (SEQ_W bits)
//   play_done         playback finished
//   input_done        user entry complete
//   user_seq          entered sequence (SEQ_W bits)
//   time_up           input timer expired
//   en_gen            one-cycle pulse on each entry to GEN
//   start_play        one-cycle pulse on entry to SHOW
//   enable_input      input collector enable (level, WAIT only)
//   timer_run         input timer run (level, WAIT only)
//   state_out         current state code
//   round_num         current round, 1-based
//   score             rounds passed
//   lives_left        remaining lives
//   round_clear       one-cycle pulse on entry to PASS
//   round_fail        one-cycle pulse on entry to FAIL
//   is_correct        level, result of the last check
//   game_clear        level while in CLEAR
//   game_over         level while in OVER

module game_round_ctrl #(
  parameter int SEQ_W      = 32,
  parameter int ROUND_W    = 3,
  parameter int NUM_ROUNDS = 6,
  parameter int LIVES      = 3,
  parameter int LIVES_W    = 2,
  parameter int TMR_W      = 28,
  parameter int START_CYC  = 150000000,
  parameter int CHECK_CYC  = 25000000,
  parameter int RESULT_CYC = 150000000,
  parameter int RETRY_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               seq_ready,
  input  logic [SEQ_W-1:0]   answer_seq,
  input  logic               play_done,
  input  logic               input_done,
  input  logic [SEQ_W-1:0]   user_seq,
  input  logic               time_up,
  output logic               en_gen,
  output logic               start_play,
  output logic               enable_input,
  output logic               timer_run,
  output logic [3:0]         state_out,
  output logic [ROUND_W-1:0] round_num,
  output logic [ROUND_W-1:0] score,
  output logic [LIVES_W-1:0] lives_left,
  output logic               round_clear,
  output logic               round_fail,
  output logic               is_correct,
  output logic               game_clear,
  output logic               game_over
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GEN   = 4'd1,
    S_SHOW  = 4'd2,
    S_WAIT  = 4'd3,
    S_CHECK = 4'd4,
    S_PASS  = 4'd5,
    S_FAIL  = 4'd6,
    S_CLEAR = 4'd7,
    S_OVER  = 4'd8
  } state_t;

  // Terminal counts of the dwell timer, pre-sized to the timer width.
  localparam logic [TMR_W-1:0]   START_LAST  = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0]   CHECK_LAST  = TMR_W'(CHECK_CYC - 1);
  localparam logic [TMR_W-1:0]   RESULT_LAST = TMR_W'(RESULT_CYC - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS);
  localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] timer;

  logic state_change;
  logic timer_counts;
  logic enter_gen;
  logic enter_show;
  logic enter_pass;
  logic enter_fail;
  logic advance_round;
  logic last_round;

  assign last_round   = (round_num == LAST_ROUND);
  assign state_change = (next_state != state);

  // The dwell timer only matters in states that leave on a fixed delay.
  assign timer_counts = (state == S_IDLE) || (state == S_CHECK) ||
                        (state == S_PASS) || (state == S_FAIL);

  assign enter_gen  = (next_state == S_GEN)  && (state != S_GEN);
  assign enter_show = (next_state == S_SHOW) && (state != S_SHOW);
  assign enter_pass = (next_state == S_PASS) && (state != S_PASS);
  assign enter_fail = (next_state == S_FAIL) && (state != S_FAIL);

  // A round is consumed on PASS->GEN always, and on FAIL->GEN only when a
  // failed round is not replayed.
  assign advance_round = ((state == S_PASS) && (next_state == S_GEN)) ||
                         ((state == S_FAIL) && (next_state == S_GEN) && (RETRY_MODE == 0));

  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (timer == START_LAST) next_state = S_GEN;
        end
        S_GEN: begin
          if (seq_ready) next_state = S_SHOW;
        end
        S_SHOW: begin
          // start_play is high in the first SHOW cycle; a play_done seen
          // then belongs to the previous playback, not the one just started.
          if (play_done && !start_play) next_state = S_WAIT;
        end
        S_WAIT: begin
          // Timeout beats a coincident entry.
          if (time_up)         next_state = S_FAIL;
          else if (input_done) next_state = S_CHECK;
        end
        S_CHECK: begin
          if (timer == CHECK_LAST) begin
            if (answer_seq == user_seq) next_state = S_PASS;
            else                        next_state = S_FAIL;
          end
        end
        S_PASS: begin
          if (timer == RESULT_LAST) begin
            if (last_round) next_state = S_CLEAR;
            else            next_state = S_GEN;
          end
        end
        S_FAIL: begin
          // lives_left was already decremented on FAIL entry.
          if (timer == RESULT_LAST) begin
            if (lives_left == '0)    next_state = S_OVER;
            else if (RETRY_MODE != 0) next_state = S_GEN;
            else if (last_round)     next_state = S_OVER;
            else                     next_state = S_GEN;
          end
        end
        S_CLEAR: next_state = S_CLEAR;
        S_OVER:  next_state = S_OVER;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      round_num    <= FIRST_ROUND;
      score        <= '0;
      lives_left   <= LIVES_INIT;
      en_gen       <= 1'b0;
      start_play   <= 1'b0;
      enable_input <= 1'b0;
      timer_run    <= 1'b0;
      state_out    <= S_IDLE;
      round_clear  <= 1'b0;
      round_fail   <= 1'b0;
      is_correct   <= 1'b0;
      game_clear   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state <= next_state;

      // Dwell timer: restarts from 0 in each new state, saturates at all-ones.
      if (state_change || restart) begin
        timer <= '0;
      end else if (timer_counts) begin
        if (timer != '1) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (restart) begin
        round_num  <= FIRST_ROUND;
        score      <= '0;
        lives_left <= LIVES_INIT;
      end else begin
        if (enter_pass) score <= score + 1'b1;
        if (enter_fail && (lives_left != '0)) lives_left <= lives_left - 1'b1;
        if (advance_round) round_num <= round_num + 1'b1;
      end

      // Registered outputs decoded from next_state.
      state_out    <= next_state;
      en_gen       <= enter_gen;
      start_play   <= enter_show;
      enable_input <= (next_state == S_WAIT);
      timer_run    <= (next_state == S_WAIT);
      round_clear  <= enter_pass;
      round_fail   <= enter_fail;
      game_clear   <= (next_state == S_CLEAR);
      game_over    <= (next_state == S_OVER);

      // is_correct persists through GEN..CHECK and the terminal states.
      if (restart)         is_correct <= 1'b0;
      else if (enter_pass) is_correct <= 1'b1;
      else if (enter_fail) is_correct <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: two instances (advance-on-fail and retry-on-fail).
// State transitions are checked against a scoreboard queue filled as stimulus is driven.
// Outputs are sampled on the falling clock edge; inputs change right after sampling.

module tb_game_round_ctrl;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GEN   = 4'd1;
  localparam logic [3:0] S_SHOW  = 4'd2;
  localparam logic [3:0] S_WAIT  = 4'd3;
  localparam logic [3:0] S_CHECK = 4'd4;
  localparam logic [3:0] S_PASS  = 4'd5;
  localparam logic [3:0] S_FAIL  = 4'd6;
  localparam logic [3:0] S_CLEAR = 4'd7;
  localparam logic [3:0] S_OVER  = 4'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] restart;
  logic [1:0] seq_ready;
  logic [1:0] play_done;
  logic [1:0] input_done;
  logic [1:0] time_up;
  logic [7:0] answer_seq [2];
  logic [7:0] user_seq   [2];

  logic       en_gen       [2];
  logic       start_play   [2];
  logic       enable_input [2];
  logic       timer_run    [2];
  logic [3:0] state_out    [2];
  logic [2:0] round_num    [2];
  logic [2:0] score        [2];
  logic [1:0] lives_left   [2];
  logic       round_clear  [2];
  logic       round_fail   [2];
  logic       is_correct   [2];
  logic       game_clear   [2];
  logic       game_over    [2];

  int compared   = 0;
  int mismatched = 0;
  int en_cnt    [2];
  int start_cnt [2];
  int clear_cnt [2];
  int fail_cnt  [2];
  logic [3:0] prev_st [2];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  always #5 clk = ~clk;

  game_round_ctrl #(
    .SEQ_W(8), .ROUND_W(3), .NUM_ROUNDS(3), .LIVES(2), .LIVES_W(2), .TMR_W(8),
    .START_CYC(10), .CHECK_CYC(4), .RESULT_CYC(8), .RETRY_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .restart(restart[0]), .seq_ready(seq_ready[0]),
    .answer_seq(answer_seq[0]), .play_done(play_done[0]), .input_done(input_done[0]),
    .user_seq(user_seq[0]), .time_up(time_up[0]), .en_gen(en_gen[0]),
    .start_play(start_play[0]), .enable_input(enable_input[0]), .timer_run(timer_run[0]),
    .state_out(state_out[0]), .round_num(round_num[0]), .score(score[0]),
    .lives_left(lives_left[0]), .round_clear(round_clear[0]), .round_fail(round_fail[0]),
    .is_correct(is_correct[0]), .game_clear(game_clear[0]), .game_over(game_over[0])
  );

  game_round_ctrl #(
    .SEQ_W(8), .ROUND_W(3), .NUM_ROUNDS(3), .LIVES(2), .LIVES_W(2), .TMR_W(8),
    .START_CYC(10), .CHECK_CYC(4), .RESULT_CYC(8), .RETRY_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .restart(restart[1]), .seq_ready(seq_ready[1]),
    .answer_seq(answer_seq[1]), .play_done(play_done[1]), .input_done(input_done[1]),
    .user_seq(user_seq[1]), .time_up(time_up[1]), .en_gen(en_gen[1]),
    .start_play(start_play[1]), .enable_input(enable_input[1]), .timer_run(timer_run[1]),
    .state_out(state_out[1]), .round_num(round_num[1]), .score(score[1]),
    .lives_left(lives_left[1]), .round_clear(round_clear[1]), .round_fail(round_fail[1]),
    .is_correct(is_correct[1]), .game_clear(game_clear[1]), .game_over(game_over[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int k, input logic [3:0] st);
    if (k == 0) q0.push_back(st);
    else        q1.push_back(st);
  endtask

  // One clock: sample on the falling edge, count pulses, score any state change.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (en_gen[k] === 1'b1)      en_cnt[k]++;
      if (start_play[k] === 1'b1)  start_cnt[k]++;
      if (round_clear[k] === 1'b1) clear_cnt[k]++;
      if (round_fail[k] === 1'b1)  fail_cnt[k]++;
      if (state_out[k] !== prev_st[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          check(k == 0 ? "sb_extra_dut0" : "sb_extra_dut1", 32'(state_out[k]), 32'hF);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check(k == 0 ? "sb_state_dut0" : "sb_state_dut1", 32'(state_out[k]), 32'(e));
        end
        prev_st[k] = state_out[k];
      end
    end
  endtask

  task automatic wait_state(input int k, input logic [3:0] target, input int budget, output int n);
    n = 0;
    while (state_out[k] !== target && n < budget) begin
      step();
      n++;
    end
    check("reach_state", 32'(state_out[k]), 32'(target));
  endtask

  // GEN -> SHOW -> WAIT -> CHECK with user entry usr.
  task automatic to_check(input int k, input logic [7:0] usr);
    seq_ready[k] = 1'b1; push(k, S_SHOW); step(); seq_ready[k] = 1'b0;
    step();
    play_done[k] = 1'b1; push(k, S_WAIT); step(); play_done[k] = 1'b0;
    user_seq[k] = usr; input_done[k] = 1'b1; push(k, S_CHECK); step(); input_done[k] = 1'b0;
  endtask

  task automatic play_round(input int k, input logic [7:0] usr, input bit pass);
    int n;
    to_check(k, usr);
    push(k, pass ? S_PASS : S_FAIL);
    wait_state(k, pass ? S_PASS : S_FAIL, 12, n);
  endtask

  initial begin
    int n;
    rst_n = 1'b1; restart = '0; seq_ready = '0; play_done = '0;
    input_done = '0; time_up = '0;
    answer_seq[0] = 8'hA5; user_seq[0] = 8'h00;
    answer_seq[1] = 8'h12; user_seq[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      en_cnt[k] = 0; start_cnt[k] = 0; clear_cnt[k] = 0; fail_cnt[k] = 0;
      prev_st[k] = S_IDLE;
    end
    #2 rst_n = 1'b0;
    step(); step();

    // Reset values
    check("rst_state", 32'(state_out[0]), 32'(S_IDLE));
    check("rst_round", 32'(round_num[0]), 1);
    check("rst_score", 32'(score[0]), 0);
    check("rst_lives", 32'(lives_left[0]), 2);
    check("rst_outs", 32'({en_gen[0], start_play[0], enable_input[0], timer_run[0],
                           round_clear[0], round_fail[0], is_correct[0], game_clear[0],
                           game_over[0]}), 0);

    // IDLE dwell then GEN
    rst_n = 1'b1;
    push(0, S_GEN); push(1, S_GEN);
    n = 0;
    while (en_gen[0] !== 1'b1 && n < 30) begin step(); n++; end
    check("idle_dwell_cycles", n, 10);
    check("gen_state", 32'(state_out[0]), 32'(S_GEN));
    check("gen_round", 32'(round_num[0]), 1);
    check("gen_lives", 32'(lives_left[0]), 2);
    step(); step(); step();
    check("en_gen_once", en_cnt[0], 1);
    check("dut1_gen", 32'(state_out[1]), 32'(S_GEN));

    // play_done coincident with start_play is ignored
    seq_ready[0] = 1'b1; push(0, S_SHOW); step(); seq_ready[0] = 1'b0;
    check("start_play_pulse", 32'(start_play[0]), 1);
    play_done[0] = 1'b1; step(); play_done[0] = 1'b0;
    check("show_hold", 32'(state_out[0]), 32'(S_SHOW));
    step(); step(); step(); step();
    play_done[0] = 1'b1; push(0, S_WAIT); step(); play_done[0] = 1'b0;
    check("wait_state", 32'(state_out[0]), 32'(S_WAIT));
    check("wait_enable_input", 32'(enable_input[0]), 1);
    check("wait_timer_run", 32'(timer_run[0]), 1);
    check("start_play_once", start_cnt[0], 1);

    // Full game on dut0: three passes
    user_seq[0] = 8'hA5; input_done[0] = 1'b1; push(0, S_CHECK); step(); input_done[0] = 1'b0;
    check("check_enable_input", 32'(enable_input[0]), 0);
    check("check_timer_run", 32'(timer_run[0]), 0);
    push(0, S_PASS); wait_state(0, S_PASS, 12, n);
    check("check_dwell", n, 4);
    check("pass_round_clear", 32'(round_clear[0]), 1);
    check("pass_is_correct", 32'(is_correct[0]), 1);
    check("pass_score1", 32'(score[0]), 1);
    push(0, S_GEN); wait_state(0, S_GEN, 12, n);
    check("pass_dwell", n, 8);
    check("round2", 32'(round_num[0]), 2);
    play_round(0, 8'hA5, 1'b1);
    push(0, S_GEN); wait_state(0, S_GEN, 12, n);
    check("round3", 32'(round_num[0]), 3);
    play_round(0, 8'hA5, 1'b1);
    push(0, S_CLEAR); wait_state(0, S_CLEAR, 12, n);
    check("clear_pulses", clear_cnt[0], 3);
    check("clear_score", 32'(score[0]), 3);
    check("clear_flag", 32'(game_clear[0]), 1);
    check("clear_round", 32'(round_num[0]), 3);
    for (int i = 0; i < 20; i++) step();
    check("clear_no_more_gen", en_cnt[0], 3);
    check("clear_stays", 32'(state_out[0]), 32'(S_CLEAR));

    // Retry mode on dut1: two mismatches
    play_round(1, 8'h13, 1'b0);
    check("retry_fail_pulse", 32'(round_fail[1]), 1);
    check("retry_lives1", 32'(lives_left[1]), 1);
    check("retry_is_correct", 32'(is_correct[1]), 0);
    push(1, S_GEN); wait_state(1, S_GEN, 12, n);
    check("retry_round_same", 32'(round_num[1]), 1);
    check("retry_en_gen", en_cnt[1], 2);
    play_round(1, 8'h13, 1'b0);
    check("retry_lives0", 32'(lives_left[1]), 0);
    push(1, S_OVER); wait_state(1, S_OVER, 12, n);
    check("retry_over_flag", 32'(game_over[1]), 1);
    check("retry_fail_count", fail_cnt[1], 2);

    // Advance mode on dut0: restart from CLEAR, then time_up beats input_done
    restart[0] = 1'b1; push(0, S_IDLE); step(); restart[0] = 1'b0;
    check("restart_clear_state", 32'(state_out[0]), 32'(S_IDLE));
    check("restart_clear_flag", 32'(game_clear[0]), 0);
    check("restart_clear_score", 32'(score[0]), 0);
    push(0, S_GEN); wait_state(0, S_GEN, 15, n);
    play_round(0, 8'hA5, 1'b1);
    push(0, S_GEN); wait_state(0, S_GEN, 12, n);
    seq_ready[0] = 1'b1; push(0, S_SHOW); step(); seq_ready[0] = 1'b0;
    step();
    play_done[0] = 1'b1; push(0, S_WAIT); step(); play_done[0] = 1'b0;
    time_up[0] = 1'b1; input_done[0] = 1'b1; user_seq[0] = 8'hA5;
    push(0, S_FAIL); step();
    time_up[0] = 1'b0; input_done[0] = 1'b0;
    check("timeup_wins", 32'(state_out[0]), 32'(S_FAIL));
    check("timeup_fail_pulse", 32'(round_fail[0]), 1);
    check("timeup_lives", 32'(lives_left[0]), 1);
    push(0, S_GEN); wait_state(0, S_GEN, 12, n);
    check("advance_round3", 32'(round_num[0]), 3);
    play_round(0, 8'h00, 1'b0);
    check("r3_lives0", 32'(lives_left[0]), 0);
    push(0, S_OVER); wait_state(0, S_OVER, 12, n);
    check("r3_over_flag", 32'(game_over[0]), 1);

    // restart from OVER
    restart[0] = 1'b1; push(0, S_IDLE); step(); restart[0] = 1'b0;
    check("rs_over_state", 32'(state_out[0]), 32'(S_IDLE));
    check("rs_over_round", 32'(round_num[0]), 1);
    check("rs_over_score", 32'(score[0]), 0);
    check("rs_over_lives", 32'(lives_left[0]), 2);
    check("rs_over_outs", 32'({en_gen[0], start_play[0], round_clear[0], round_fail[0],
                               is_correct[0], game_over[0], game_clear[0]}), 0);

    // restart from CHECK after one passed round
    push(0, S_GEN); wait_state(0, S_GEN, 15, n);
    play_round(0, 8'hA5, 1'b1);
    push(0, S_GEN); wait_state(0, S_GEN, 12, n);
    to_check(0, 8'hA5);
    step();
    check("rs_check_pre_score", 32'(score[0]), 1);
    restart[0] = 1'b1; push(0, S_IDLE); step(); restart[0] = 1'b0;
    check("rs_check_state", 32'(state_out[0]), 32'(S_IDLE));
    check("rs_check_round", 32'(round_num[0]), 1);
    check("rs_check_score", 32'(score[0]), 0);
    check("rs_check_lives", 32'(lives_left[0]), 2);
    check("rs_check_outs", 32'({en_gen[0], start_play[0], enable_input[0], timer_run[0],
                                round_clear[0], round_fail[0], is_correct[0]}), 0);

    // Asynchronous reset mid-SHOW
    push(0, S_GEN); wait_state(0, S_GEN, 15, n);
    seq_ready[0] = 1'b1; push(0, S_SHOW); step(); seq_ready[0] = 1'b0;
    push(0, S_IDLE); push(1, S_IDLE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_out[0]), 32'(S_IDLE));
    check("arst_round", 32'(round_num[0]), 1);
    check("arst_score", 32'(score[0]), 0);
    check("arst_lives", 32'(lives_left[0]), 2);
    check("arst_start_play", 32'(start_play[0]), 0);
    check("arst_dut1_over", 32'(game_over[1]), 0);
    check("arst_dut1_lives", 32'(lives_left[1]), 2);
    step(); step();
    check("arst_no_pulses", 32'({en_gen[0], start_play[0], round_clear[0], round_fail[0]}), 0);
    rst_n = 1'b1;

    check("sb_drain_dut0", q0.size(), 0);
    check("sb_drain_dut1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
